onehot_phase_monitor: RTL

Downstream consumer of the 3-phase one-hot up counter. Samples the counter's one-hot state every clock and checks it for legality and legal succession. Also encodes the active phase to binary, counts completed rotations and raises sticky fault flags. It sits between the counter and the display/control logic, which uses only `index`/`valid` and never the raw one-hot bits.

---
 rtl/onehot_phase_monitor.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/onehot_phase_monitor.sv
// ---------------------------------------------------------------------------
// onehot_phase_monitor
//
// Watches the state of a one-hot rotating phase counter. It checks that the
// state is legal and that each change is a legal advance. It also reports the
// tracked phase as a binary index, counts completed rotations and keeps
// sticky fault flags. Downstream logic uses index/valid and never the raw
// one-hot bits.
//
// Parameters:
//   N  - one-hot phase width (N >= 2)
//   CW - rotation counter width
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   asynchronous, active-low reset
//   phase       in   [N]   one-hot counter state, legal advance bit k -> k+1 mod N
//   clear_err   in   synchronous clear of the fault flags (level-sampled)
//   valid       out  high while tracking a legal phase
//   index       out  [clog2(N)] binary number of the tracked phase bit
//   step        out  one-cycle pulse per legal advance
//   rot_count   out  [CW] completed rotations, modulo 2^CW
//   rot_wrap    out  one-cycle pulse when rot_count wraps to 0
//   err_illegal out  sticky: phase was not one-hot while tracking
//   err_skip    out  sticky: phase jumped to a legal non-successor bit
// ---------------------------------------------------------------------------
module onehot_phase_monitor #(
    parameter int N  = 3,
    parameter int CW = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         phase,
    input  logic                 clear_err,
    output logic                 valid,
    output logic [$clog2(N)-1:0] index,
    output logic                 step,
    output logic [CW-1:0]        rot_count,
    output logic                 rot_wrap,
    output logic                 err_illegal,
    output logic                 err_skip
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FAULT
    } state_t;

    state_t         state, state_next;
    logic [N-1:0]   prev, prev_next;
    logic [IW-1:0]  index_next;
    logic           valid_next;
    logic           step_next;
    logic [CW-1:0]  rot_count_next;
    logic           rot_wrap_next;
    logic           err_illegal_next;
    logic           err_skip_next;

    logic           legal;
    logic [N-1:0]   successor;

    // Exactly one bit set; all-zero and multi-hot are both illegal.
    function automatic logic is_onehot(input logic [N-1:0] p);
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            cnt += int'(p[i]);
        end
        return (cnt == 1);
    endfunction

    // Position of the set bit; 0 when no bit is set (only after reset).
    function automatic logic [IW-1:0] encode(input logic [N-1:0] p);
        logic [IW-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                e = IW'(i);
            end
        end
        return e;
    endfunction

    assign legal     = is_onehot(phase);
    assign successor = {prev[N-2:0], prev[N-1]};

    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned; that is what keeps this combinational block latch-free.
    always_comb begin
        state_next       = state;
        prev_next        = prev;
        step_next        = 1'b0;
        rot_wrap_next    = 1'b0;
        rot_count_next   = rot_count;
        err_illegal_next = err_illegal;
        err_skip_next    = err_skip;

        // Clearing comes first so that a flag set below in the same cycle wins.
        if (clear_err) begin
            err_illegal_next = 1'b0;
            err_skip_next    = 1'b0;
        end

        unique case (state)
            IDLE: begin
                // Illegal phases are tolerated silently here (startup).
                if (legal) begin
                    prev_next  = phase;
                    state_next = TRACK;
                end
            end

            TRACK: begin
                if (!legal) begin
                    err_illegal_next = 1'b1;
                    state_next       = FAULT;
                end else if (phase == prev) begin
                    // Holding the same phase: nothing to report.
                end else if (phase == successor) begin
                    step_next = 1'b1;
                    prev_next = phase;
                    // Moving out of the top bit completes one rotation.
                    if (prev[N-1]) begin
                        rot_count_next = rot_count + CW'(1);
                        rot_wrap_next  = &rot_count;
                    end
                end else begin
                    // Legal but out of order: flag it and resync to the new bit.
                    err_skip_next = 1'b1;
                    prev_next     = phase;
                end
            end

            FAULT: begin
                // Flags are already cleared above when clear_err is high.
                if (clear_err) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign valid_next = (state_next == TRACK);
    assign index_next = encode(prev_next);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prev        <= '0;
            valid       <= 1'b0;
            index       <= '0;
            step        <= 1'b0;
            rot_count   <= '0;
            rot_wrap    <= 1'b0;
            err_illegal <= 1'b0;
            err_skip    <= 1'b0;
        end else begin
            state       <= state_next;
            prev        <= prev_next;
            valid       <= valid_next;
            index       <= index_next;
            step        <= step_next;
            rot_count   <= rot_count_next;
            rot_wrap    <= rot_wrap_next;
            err_illegal <= err_illegal_next;
            err_skip    <= err_skip_next;
        end
    end

endmodule
